// File: rtl/wb_arb_pkg.sv
// Shared widths and stall-counter constants for the writeback arbiter.
// The stall counters are built only when WB_ARB_STATS_EN is defined.
package wb_arb_pkg;

    localparam int unsigned DEF_DW  = 32;
    localparam int unsigned DEF_AW  = 5;
    localparam int unsigned DEF_TW  = 4;
    localparam int unsigned STALL_W = 16;

    typedef logic [STALL_W-1:0] stall_cnt_t;

    localparam stall_cnt_t STALL_SAT = 16'hFFFF;

    function automatic stall_cnt_t sat_inc(input stall_cnt_t v);
        return (v == STALL_SAT) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-winner round-robin picker.
// Grant B must not share grant A's destination address.
module rr_pick2
    import wb_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = DEF_AW,
    parameter int unsigned PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]    valid_i,
    input  logic [NREQ*AW-1:0] addr_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [NREQ-1:0]    gnt_a_o,
    output logic [NREQ-1:0]    gnt_b_o,
    output logic               found_a_o,
    output logic               found_b_o,
    output logic [PW-1:0]      ptr_o
);

    logic [AW-1:0] addr_a;
    logic [PW-1:0] idx;
    logic [PW-1:0] last_idx;

    always_comb begin
        gnt_a_o   = '0;
        gnt_b_o   = '0;
        found_a_o = 1'b0;
        found_b_o = 1'b0;
        addr_a    = '0;
        idx       = '0;
        last_idx  = ptr_i;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = PW'((32'(ptr_i) + k) % NREQ);
            if (valid_i[idx]) begin
                if (!found_a_o) begin
                    found_a_o    = 1'b1;
                    gnt_a_o[idx] = 1'b1;
                    addr_a       = addr_i[idx*AW +: AW];
                    last_idx     = idx;
                end else if (!found_b_o && (addr_i[idx*AW +: AW] != addr_a)) begin
                    // Same-address requesters are skipped, not blocking the scan.
                    found_b_o    = 1'b1;
                    gnt_b_o[idx] = 1'b1;
                    last_idx     = idx;
                end
            end
        end
        ptr_o = found_a_o ? PW'((32'(last_idx) + 1) % NREQ) : ptr_i;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing two register-file writeback ports among NREQ producers.
// Optional per-requester stall counters are enabled by WB_ARB_STATS_EN.
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = DEF_DW,
    parameter int unsigned AW   = DEF_AW,
    parameter int unsigned TW   = DEF_TW
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               flush,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ*TW-1:0] req_tag,
    output logic               WE1,
    output logic [AW-1:0]      WA1,
    output logic [DW-1:0]      WD1,
    output logic [TW-1:0]      WT1,
    output logic               WE2,
    output logic [AW-1:0]      WA2,
    output logic [DW-1:0]      WD2,
    output logic [TW-1:0]      WT2
`ifdef WB_ARB_STATS_EN
    ,
    output logic [NREQ*STALL_W-1:0] stall_cnt
`endif
);

    localparam int unsigned PW = $clog2(NREQ);

    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   ptr_d;
    logic [NREQ-1:0] gnt_a;
    logic [NREQ-1:0] gnt_b;
    logic            found_a;
    logic            found_b;
    logic [AW-1:0]   a_addr, b_addr;
    logic [DW-1:0]   a_data, b_data;
    logic [TW-1:0]   a_tag, b_tag;

    rr_pick2 #(
        .NREQ (NREQ),
        .AW   (AW),
        .PW   (PW)
    ) u_pick (
        .valid_i   (req_valid),
        .addr_i    (req_addr),
        .ptr_i     (ptr_q),
        .gnt_a_o   (gnt_a),
        .gnt_b_o   (gnt_b),
        .found_a_o (found_a),
        .found_b_o (found_b),
        .ptr_o     (ptr_d)
    );

    assign req_ready = (reset || flush) ? '0 : (gnt_a | gnt_b);

    // One-hot grants select the winning payloads by OR-reduction.
    always_comb begin
        a_addr = '0;
        a_data = '0;
        a_tag  = '0;
        b_addr = '0;
        b_data = '0;
        b_tag  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_a[i]) begin
                a_addr = a_addr | req_addr[i*AW +: AW];
                a_data = a_data | req_data[i*DW +: DW];
                a_tag  = a_tag  | req_tag[i*TW +: TW];
            end
            if (gnt_b[i]) begin
                b_addr = b_addr | req_addr[i*AW +: AW];
                b_data = b_data | req_data[i*DW +: DW];
                b_tag  = b_tag  | req_tag[i*TW +: TW];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            ptr_q <= '0;
            WE1   <= 1'b0;
            WA1   <= '0;
            WD1   <= '0;
            WT1   <= '0;
            WE2   <= 1'b0;
            WA2   <= '0;
            WD2   <= '0;
            WT2   <= '0;
        end else if (flush) begin
            ptr_q <= '0;
            WE1   <= 1'b0;
            WE2   <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            WE1   <= found_a;
            WE2   <= found_b;
            if (found_a) begin
                WA1 <= a_addr;
                WD1 <= a_data;
                WT1 <= a_tag;
            end
            if (found_b) begin
                WA2 <= b_addr;
                WD2 <= b_data;
                WT2 <= b_tag;
            end
        end
    end

`ifdef WB_ARB_STATS_EN
    stall_cnt_t stall_q [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_stats
        always_ff @(posedge CLK) begin
            if (reset) begin
                stall_q[g] <= '0;
            end else if (req_valid[g] && !req_ready[g]) begin
                stall_q[g] <= sat_inc(stall_q[g]);
            end
        end
        assign stall_cnt[g*STALL_W +: STALL_W] = stall_q[g];
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (NREQ=4); stats checks need WB_ARB_STATS_EN.
module tb_wb_arbiter;

    logic         CLK;
    logic         reset;
    logic         flush;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [19:0]  req_addr;
    logic [127:0] req_data;
    logic [15:0]  req_tag;
    logic         WE1, WE2;
    logic [4:0]   WA1, WA2;
    logic [31:0]  WD1, WD2;
    logic [3:0]   WT1, WT2;
`ifdef WB_ARB_STATS_EN
    logic [63:0]  stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    wb_arbiter #(
        .NREQ (4),
        .DW   (32),
        .AW   (5),
        .TW   (4)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_tag   (req_tag),
        .WE1       (WE1),
        .WA1       (WA1),
        .WD1       (WD1),
        .WT1       (WT1),
        .WE2       (WE2),
        .WA2       (WA2),
        .WD2       (WD2),
        .WT2       (WT2)
`ifdef WB_ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] a,
                           input logic [31:0] d, input logic [3:0] t);
        req_valid[i]        = v;
        req_addr[i*5 +: 5]  = a;
        req_data[i*32 +: 32] = d;
        req_tag[i*4 +: 4]   = t;
    endtask

    task automatic set_all_distinct();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 5'(i + 1), 32'h100 + 32'(i), 4'(i + 8));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_req(2, 1'b1, 5'd3, 32'h1234_5678, 4'd1);
        step();
        step();
        #2;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        reset = 1'b0;
        req_valid = '0;
        checks++; if ({WE1, WE2} !== 2'b00) begin errors++; $display("FAIL reset_we: got %b want 00", {WE1, WE2}); end
        checks++; if ({WA1, WD1, WT1} !== '0) begin errors++; $display("FAIL reset_port1: got %h want 0", {WA1, WD1, WT1}); end
        checks++; if ({WA2, WD2, WT2} !== '0) begin errors++; $display("FAIL reset_port2: got %h want 0", {WA2, WD2, WT2}); end
`ifdef WB_ARB_STATS_EN
        checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_stats: got %h want 0", stall_cnt); end
`endif
        step();
    endtask

    task automatic test_single();
        set_req(2, 1'b1, 5'd7, 32'hDEAD_BEEF, 4'd3);
        #2;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        step();
        req_valid = '0;
        checks++; if (WE1 !== 1'b1 || WA1 !== 5'd7) begin errors++; $display("FAIL single_port1: got we=%b wa=%0d want we=1 wa=7", WE1, WA1); end
        checks++; if (WD1 !== 32'hDEAD_BEEF || WT1 !== 4'd3) begin errors++; $display("FAIL single_data: got wd=%h wt=%0d want wd=deadbeef wt=3", WD1, WT1); end
        checks++; if (WE2 !== 1'b0) begin errors++; $display("FAIL single_we2: got %b want 0", WE2); end
        // ptr is now 3, so requester 3 wins port 1 and requester 0 port 2.
        set_all_distinct();
        #2;
        checks++; if (req_ready !== 4'b1001) begin errors++; $display("FAIL single_ptr: got %b want 1001", req_ready); end
        flush = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_flush_ready: got %b want 0000", req_ready); end
        step();
        flush = 1'b0;
        req_valid = '0;
        checks++; if ({WE1, WE2} !== 2'b00) begin errors++; $display("FAIL single_flush_we: got %b want 00", {WE1, WE2}); end
    endtask

    task automatic test_all_four();
        set_all_distinct();
        #2;
        checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL all4_c0_ready: got %b want 0011", req_ready); end
        step();
        checks++; if ({WE1, WA1, WD1, WT1} !== {1'b1, 5'd1, 32'h100, 4'd8}) begin errors++; $display("FAIL all4_c0_p1: got %h want 1_01_00000100_8", {WE1, WA1, WD1, WT1}); end
        checks++; if ({WE2, WA2, WD2, WT2} !== {1'b1, 5'd2, 32'h101, 4'd9}) begin errors++; $display("FAIL all4_c0_p2: got %h want 1_02_00000101_9", {WE2, WA2, WD2, WT2}); end
        #2;
        checks++; if (req_ready !== 4'b1100) begin errors++; $display("FAIL all4_c1_ready: got %b want 1100", req_ready); end
        step();
        checks++; if ({WE1, WA1, WE2, WA2} !== {1'b1, 5'd3, 1'b1, 5'd4}) begin errors++; $display("FAIL all4_c1_ports: got wa1=%0d wa2=%0d we=%b%b want 3/4 11", WA1, WA2, WE1, WE2); end
        #2;
        checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL all4_ptr_wrap: got %b want 0011", req_ready); end
        req_valid = '0;
        step();
        checks++; if ({WE1, WE2} !== 2'b00) begin errors++; $display("FAIL all4_idle_we: got %b want 00", {WE1, WE2}); end
    endtask

    task automatic test_conflict();
        set_req(0, 1'b1, 5'd9, 32'hAAAA_0000, 4'd1);
        set_req(1, 1'b1, 5'd9, 32'hBBBB_1111, 4'd2);
        set_req(2, 1'b1, 5'd5, 32'hCCCC_2222, 4'd3);
        set_req(3, 1'b0, 5'd9, 32'h0, 4'd0);
        #2;
        checks++; if (req_ready !== 4'b0101) begin errors++; $display("FAIL conflict_c0_ready: got %b want 0101", req_ready); end
        step();
        checks++; if ({WE1, WA1, WD1, WT1} !== {1'b1, 5'd9, 32'hAAAA_0000, 4'd1}) begin errors++; $display("FAIL conflict_c0_p1: got %h want 1_09_aaaa0000_1", {WE1, WA1, WD1, WT1}); end
        checks++; if ({WE2, WA2, WD2, WT2} !== {1'b1, 5'd5, 32'hCCCC_2222, 4'd3}) begin errors++; $display("FAIL conflict_c0_p2: got %h want 1_05_cccc2222_3", {WE2, WA2, WD2, WT2}); end
        checks++; if (WE2 && (WA1 === WA2)) begin errors++; $display("FAIL conflict_pairing: got wa1=%0d wa2=%0d want different", WA1, WA2); end
        req_valid[0] = 1'b0;
        req_valid[2] = 1'b0;
        #2;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL conflict_c1_ready: got %b want 0010", req_ready); end
        step();
        req_valid = '0;
        checks++; if ({WE1, WA1, WD1, WT1, WE2} !== {1'b1, 5'd9, 32'hBBBB_1111, 4'd2, 1'b0}) begin errors++; $display("FAIL conflict_c1_ports: got %h want 1_09_bbbb1111_2_0", {WE1, WA1, WD1, WT1, WE2}); end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        set_all_distinct();
        #2;
        checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL flush_c0_ready: got %b want 0011", req_ready); end
        step();
        flush = 1'b1;
        #2;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL flush_c1_ready: got %b want 0000", req_ready); end
        checks++; if ({WE1, WA1, WE2, WA2} !== {1'b1, 5'd1, 1'b1, 5'd2}) begin errors++; $display("FAIL flush_c1_ports: got %h want 1_01_1_02", {WE1, WA1, WE2, WA2}); end
        step();
        flush = 1'b0;
        checks++; if ({WE1, WE2} !== 2'b00) begin errors++; $display("FAIL flush_c2_we: got %b want 00", {WE1, WE2}); end
        checks++; if (WA1 !== 5'd1 || WA2 !== 5'd2) begin errors++; $display("FAIL flush_hold_wa: got %0d/%0d want 1/2", WA1, WA2); end
        #2;
        checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL flush_resume: got %b want 0011", req_ready); end
        req_valid = '0;
        step();
    endtask

    task automatic test_reset_over_flush();
        set_all_distinct();
        step();
        checks++; if (WE1 !== 1'b1) begin errors++; $display("FAIL rof_pre_we1: got %b want 1", WE1); end
        reset = 1'b1;
        flush = 1'b1;
        #2;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rof_ready: got %b want 0000", req_ready); end
        step();
        reset = 1'b0;
        flush = 1'b0;
        checks++; if ({WE1, WA1, WD1, WT1, WE2, WA2, WD2, WT2} !== '0) begin errors++; $display("FAIL rof_outputs: got %h want 0", {WE1, WA1, WD1, WT1, WE2, WA2, WD2, WT2}); end
        #2;
        checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL rof_ptr: got %b want 0011", req_ready); end
        req_valid = '0;
        step();
    endtask

`ifdef WB_ARB_STATS_EN
    task automatic test_stats();
        logic [3:0] exp_rdy;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 5'd7, 32'(i), 4'(i));
        for (int c = 0; c < 4; c++) begin
            exp_rdy = 4'(1 << c);
            #2;
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL stats_ready_c%0d: got %b want %b", c, req_ready, exp_rdy); end
            checks++; if (stall_cnt[48 +: 16] !== 16'(c)) begin errors++; $display("FAIL stats_cnt3_c%0d: got %0d want %0d", c, stall_cnt[48 +: 16], c); end
            step();
        end
        req_valid = '0;
        checks++; if (stall_cnt[48 +: 16] !== 16'd3) begin errors++; $display("FAIL stats_cnt3_after: got %0d want 3", stall_cnt[48 +: 16]); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        // Flush keeps requester 0 ungranted so its counter climbs to saturation.
        set_req(0, 1'b1, 5'd1, 32'h0, 4'd0);
        flush = 1'b1;
        repeat (65534) step();
        checks++; if (stall_cnt[0 +: 16] !== 16'hFFFE) begin errors++; $display("FAIL stats_pre_sat: got %h want fffe", stall_cnt[0 +: 16]); end
        step();
        checks++; if (stall_cnt[0 +: 16] !== 16'hFFFF) begin errors++; $display("FAIL stats_sat: got %h want ffff", stall_cnt[0 +: 16]); end
        step();
        checks++; if (stall_cnt[0 +: 16] !== 16'hFFFF) begin errors++; $display("FAIL stats_sat_hold: got %h want ffff", stall_cnt[0 +: 16]); end
        flush = 1'b0;
        req_valid = '0;
        step();
    endtask
`endif

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        req_tag   = '0;
        test_reset();
        test_single();
        test_all_four();
        test_conflict();
        test_flush();
        test_reset_over_flush();
`ifdef WB_ARB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
